// File: rtl/soc_sysid_arbiter_if.sv
// Bus bundle for the two-master system-ID read arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both requesting masters plus the shared control slave.
interface soc_sysid_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              m0_read;
  logic              m0_address;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic              m1_read;
  logic              m1_address;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic              s_read;
  logic              s_address;
  logic [DATA_W-1:0] s_readdata;

  modport slave (
    input  m0_read, m0_address, m1_read, m1_address, s_readdata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_read, s_address
  );

  modport master (
    output m0_read, m0_address, m1_read, m1_address, s_readdata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_read, s_address
  );
endinterface

// File: rtl/soc_sysid_arbiter.sv
// Two-master round-robin arbiter in front of a single shared control slave.
// One slave read is outstanding at a time: IDLE -> ISSUE -> WAIT* -> RESP.
// The slave's read data is sampled READ_LATENCY cycles after the ISSUE
// cycle and returned to the granted master in RESP.
module soc_sysid_arbiter #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0
) (
  input  logic               clock,
  input  logic               reset,
  soc_sysid_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t            state_q;
  logic              grant_q;       // 0 = m0, 1 = m1
  logic              last_grant_q;  // resets to 1 so m0 wins the first tie
  logic              addr_q;
  logic              s_read_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] m0_hold_q;
  logic [DATA_W-1:0] m1_hold_q;

  logic              win_d;
  logic              addr_d;
  logic              resp_m0;
  logic              resp_m1;

  // Pick a winner: a lone requester wins, a tie goes to the master not granted last.
  always_comb begin
    win_d = 1'b0;
    if (bus.m0_read && bus.m1_read) begin
      win_d = ~last_grant_q;
    end else if (bus.m1_read) begin
      win_d = 1'b1;
    end
  end

  assign addr_d = win_d ? bus.m1_address : bus.m0_address;

  // Transaction FSM with registered slave strobe, address, latency counter and data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= 1'b0;
      s_read_q     <= 1'b0;
      cnt_q        <= 3'd0;
      data_q       <= '0;
      m0_hold_q    <= '0;
      m1_hold_q    <= '0;
    end else begin
      s_read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.m0_read || bus.m1_read) begin
            grant_q      <= win_d;
            last_grant_q <= win_d;
            addr_q       <= addr_d;
            s_read_q     <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (READ_LATENCY == 0) begin
            data_q  <= bus.s_readdata;
            state_q <= RESP;
          end else begin
            cnt_q   <= 3'd1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == LAT) begin
            data_q  <= bus.s_readdata;
            cnt_q   <= 3'd0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        RESP: begin
          // Only a master that actually took the data keeps it as its last value.
          if (!grant_q && bus.m0_read) begin
            m0_hold_q <= data_q;
          end
          if (grant_q && bus.m1_read) begin
            m1_hold_q <= data_q;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_m0 = (state_q == RESP) && !grant_q;
  assign resp_m1 = (state_q == RESP) &&  grant_q;

  assign bus.s_read    = s_read_q;
  assign bus.s_address = addr_q;

  // A requester that dropped its read before RESP sees no valid strobe.
  assign bus.m0_waitrequest   = bus.m0_read & ~resp_m0;
  assign bus.m0_readdatavalid = bus.m0_read &  resp_m0;
  assign bus.m0_readdata      = resp_m0 ? data_q : m0_hold_q;

  assign bus.m1_waitrequest   = bus.m1_read & ~resp_m1;
  assign bus.m1_readdatavalid = bus.m1_read &  resp_m1;
  assign bus.m1_readdata      = resp_m1 ? data_q : m1_hold_q;

endmodule

// File: doc/soc_sysid_arbiter.md
SOC_SYSID_ARBITER -- requirements
Module: soc_sysid_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, slave/master read data width in bits.
REQ-002 Parameter READ_LATENCY, default 0, slave read latency in clock cycles; legal range 0..4.
REQ-003 clock  input  1  single clock for all logic; rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_read  input  1  master 0 read request; held until accepted.
REQ-006 m0_address  input  1  master 0 word address; held with m0_read.
REQ-007 m0_waitrequest  output  1  master 0 stall.
REQ-008 m0_readdata  output  DATA_W  master 0 read data.
REQ-009 m0_readdatavalid  output  1  master 0 data-valid strobe.
REQ-010 m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: identical to REQ-005..009 for master 1.
REQ-011 s_read  output  1  read strobe to shared control slave.
REQ-012 s_address  output  1  address to shared control slave.
REQ-013 s_readdata  input  DATA_W  shared slave read data.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; exactly one slave transaction outstanding at any time.
REQ-015 IDLE: if any mX_read=1, register grant and address, go to ISSUE next cycle; else stay IDLE.
REQ-016 Arbitration: single requester wins; on simultaneous requests, winner is the master not granted last (round-robin); last_grant=1 after reset, so m0 wins the first tie.
REQ-017 ISSUE: s_read=1 and s_address=latched address for exactly one cycle; next state WAIT if READ_LATENCY>0, else RESP.
REQ-018 WAIT: latency counter counts READ_LATENCY cycles after ISSUE; state advances to RESP after the final count.
REQ-019 s_readdata captured into a data register in the cycle ISSUE+READ_LATENCY (ISSUE itself when READ_LATENCY=0).
REQ-020 RESP: granted master's readdatavalid=1 and readdata=captured data for one cycle; next state IDLE unconditionally.
REQ-021 mX_waitrequest = mX_read AND NOT (state==RESP AND grant==X); combinational; the non-granted master stays stalled.
REQ-022 Latency: request first seen in IDLE at cycle 0 -> readdatavalid at cycle READ_LATENCY+2; back-to-back requests separated by one IDLE cycle.
REQ-023 mX_readdata holds its last delivered value between transactions; the non-granted master's readdata is unchanged.
REQ-024 Requester dropping mX_read before RESP: slave transaction still completes; RESP cycle occurs but mX_readdatavalid stays 0 (readdatavalid gated by mX_read); last_grant still updated.
REQ-025 last_grant updates at grant time (IDLE->ISSUE), not at RESP.
REQ-026 s_read never asserted outside ISSUE; s_address holds latched value outside ISSUE.

Reset
REQ-027 Reset asserted at any time, including mid-transaction: FSM to IDLE, s_read=0, s_address=0, m0/m1_readdata=0, m0/m1_readdatavalid=0, latency counter=0, data register=0, last_grant=1, all asynchronously.
REQ-028 During reset mX_waitrequest follows mX_read; any in-flight response is discarded; no readdatavalid on the first cycle after reset release.

Verification
REQ-029 Slave model returns address?32'h62205050:32'h0, READ_LATENCY=0; m0_read=1, m0_address=1 -> s_read pulse at cycle 1, m0_readdatavalid=1 and m0_readdata=32'h62205050 at cycle 2, m0_waitrequest low that cycle only.
REQ-030 READ_LATENCY=3; m1 reads address 0 -> m1_readdatavalid at cycle 5 with data 0; m0_readdatavalid stays 0 throughout.
REQ-031 m0 and m1 request continuously with address 1 -> grants alternate m0,m1,m0,m1; each completes with 32'h62205050; no double-grant; s_read pulses every L+3 cycles.
REQ-032 m1 starts read, drops m1_read in WAIT -> s_read issued once, no m1_readdatavalid, FSM returns to IDLE, next tie goes to m0.
REQ-033 Reset asserted during WAIT with READ_LATENCY=2 -> all outputs at reset values immediately; after release, fresh m0 request completes with correct data and latency.
REQ-034 Assertions on all runs: s_read one-hot in time per transaction, at most one readdatavalid per cycle, readdatavalid only when corresponding mX_read=1.
